// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states and the
// queue entry layout carried from the cache to the decoder.
package fetch_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int INST_W_DEF = 32;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [XLEN_DEF-1:0]   pc;
        logic [XLEN_DEF-1:0]   pred_next_pc;
        logic                  pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with synchronous flush; the caller guarantees no enqueue
// when full and no dequeue when empty.
module fetch_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       enq_i,
    input  logic [WIDTH-1:0]           enq_data_i,
    input  logic                       deq_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (deq_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({enq_i, deq_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (enq_i && !flush_i) mem_q[wr_ptr_q] <= enq_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: one outstanding cache request, predicted next-PC
// sequencing and a decoupling queue towards the decoder, flushed on redirect.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter int              INST_W      = INST_W_DEF,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         icache_req_valid,
    output logic [XLEN-1:0]              icache_req_addr,
    input  logic                         icache_req_ready,
    input  logic                         icache_resp_valid,
    input  logic [INST_W-1:0]            icache_resp_inst,
    output logic [XLEN-1:0]              pred_pc,
    input  logic [XLEN-1:0]              pred_next_pc,
    input  logic                         pred_taken,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [INST_W-1:0]            deq_inst,
    output logic [XLEN-1:0]              deq_pc,
    output logic [XLEN-1:0]              deq_pred_next_pc,
    output logic                         deq_pred_taken,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

    localparam int CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W = INST_W + 2 * XLEN + 1;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    fetch_state_e        state_q, state_d;
    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]     inflight_pc_q, inflight_pc_d;
    logic                enq, deq, req_fire;
    logic [ENTRY_W-1:0]  enq_data, head;
    logic [CW-1:0]       count;

    // With at most one request in flight and issue only from S_REQ, a free
    // slot at issue time is the reservation for the returning instruction.
    assign icache_req_valid = rst_n && rdy && (state_q == S_REQ) && (count < CW'(QUEUE_DEPTH));
    assign icache_req_addr  = fetch_pc_q;
    assign req_fire         = icache_req_valid && icache_req_ready;
    assign pred_pc          = inflight_pc_q;
    assign enq_data         = {icache_resp_inst, inflight_pc_q, pred_next_pc, pred_taken};

    assign deq_valid   = rdy && (count != '0);
    assign deq         = deq_valid && deq_ready && !redirect_valid;
    assign queue_count = count;
    assign {deq_inst, deq_pc, deq_pred_next_pc, deq_pred_taken} = (count != '0) ? head : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        enq           = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    inflight_pc_d = fetch_pc_q;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (icache_resp_valid) begin
                    enq        = 1'b1;
                    fetch_pc_d = word_align(pred_next_pc);
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (icache_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // A response arriving with the redirect is stale and settles the drop.
        if (redirect_valid) begin
            enq        = 1'b0;
            fetch_pc_d = word_align(redirect_pc);
            if ((state_q == S_REQ && req_fire) ||
                (state_q != S_REQ && !icache_resp_valid))
                state_d = S_DROP;
            else
                state_d = S_REQ;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (redirect_valid),
        .enq_i      (enq),
        .enq_data_i (enq_data),
        .deq_i      (deq),
        .head_o     (head),
        .count_o    (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a behavioural cache of
// configurable latency and a pc+4 predictor with one programmable taken jump.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic [31:0] pred_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [31:0] deq_pred_next_pc;
    logic        deq_pred_taken;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;

    logic        tk_en;
    logic [31:0] tk_pc, tk_tgt;

    logic [31:0] req_q[$];
    int          req_cyc[$];
    logic [31:0] dq_pc[$], dq_inst[$], dq_npc[$];
    logic        dq_tk[$];
    int          dq_cyc[$];

    inst_fetch_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rdy               (rdy),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_inst  (icache_resp_inst),
        .pred_pc           (pred_pc),
        .pred_next_pc      (pred_next_pc),
        .pred_taken        (pred_taken),
        .deq_valid         (deq_valid),
        .deq_ready         (deq_ready),
        .deq_inst          (deq_inst),
        .deq_pc            (deq_pc),
        .deq_pred_next_pc  (deq_pred_next_pc),
        .deq_pred_taken    (deq_pred_taken),
        .queue_count       (queue_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pred_taken   = tk_en && (pred_pc == tk_pc);
    assign pred_next_pc = pred_taken ? tk_tgt : pred_pc + 32'd4;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int n);
        int k = 0;
        while (req_q.size() < n && k < 200) begin
            step();
            k++;
        end
        if (req_q.size() < n) check_eq("wait_req_timeout", 64'(req_q.size()), 64'(n));
    endtask

    task automatic wait_deq(input int n);
        int k = 0;
        while (dq_pc.size() < n && k < 200) begin
            step();
            k++;
        end
        if (dq_pc.size() < n) check_eq("wait_deq_timeout", 64'(dq_pc.size()), 64'(n));
    endtask

    task automatic do_reset();
        rdy            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        tk_en          = 1'b0;
        rst_n          = 1'b0;
        repeat (6) step();
        req_q.delete(); req_cyc.delete();
        dq_pc.delete(); dq_inst.delete(); dq_npc.delete(); dq_tk.delete(); dq_cyc.delete();
        rst_n = 1'b1;
    endtask

    // Behavioural cache: one request at a time, answered after lat cycles.
    initial begin
        logic [31:0] a;
        icache_resp_valid = 1'b0;
        icache_resp_inst  = '0;
        forever begin
            @(negedge clk);
            if (icache_req_valid && icache_req_ready) begin
                a = icache_req_addr;
                req_q.push_back(a);
                req_cyc.push_back(cyc);
                repeat (lat) @(posedge clk);
                #1;
                icache_resp_valid = 1'b1;
                icache_resp_inst  = inst_of(a);
                @(posedge clk);
                #1;
                icache_resp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && deq_valid && deq_ready && !redirect_valid) begin
            dq_pc.push_back(deq_pc);
            dq_inst.push_back(deq_inst);
            dq_npc.push_back(deq_pred_next_pc);
            dq_tk.push_back(deq_pred_taken);
            dq_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        rdy              = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        icache_req_ready = 1'b1;
        deq_ready        = 1'b1;
        tk_en            = 1'b0;
        tk_pc            = '0;
        tk_tgt           = '0;
        repeat (2) step();
        check_eq("rst_req_valid", 64'(icache_req_valid), 64'd0);
        check_eq("rst_req_addr",  64'(icache_req_addr),  64'h0);
        check_eq("rst_deq_valid", 64'(deq_valid),        64'd0);
        check_eq("rst_count",     64'(queue_count),      64'd0);
        check_eq("rst_deq_pc",    64'(deq_pc),           64'h0);
        check_eq("rst_deq_inst",  64'(deq_inst),         64'h0);

        // Sequential fetch at single-cycle cache latency
        lat = 1;
        do_reset();
        rdy = 1'b1; deq_ready = 1'b1;
        wait_deq(3);
        check_eq("seq_req0", 64'(req_q[0]), 64'h0);
        check_eq("seq_req1", 64'(req_q[1]), 64'h4);
        check_eq("seq_req2", 64'(req_q[2]), 64'h8);
        check_eq("seq_deq0", 64'(dq_pc[0]), 64'h0);
        check_eq("seq_deq1", 64'(dq_pc[1]), 64'h4);
        check_eq("seq_deq2", 64'(dq_pc[2]), 64'h8);
        check_eq("seq_inst2", 64'(dq_inst[2]), 64'hC0DE_0008);
        check_eq("seq_latency", 64'(dq_cyc[0] - req_cyc[0]), 64'd2);
        check_eq("seq_spacing", 64'(req_cyc[1] - req_cyc[0]), 64'd2);

        // Taken prediction steers the next fetch
        do_reset();
        tk_en = 1'b1; tk_pc = 32'h4; tk_tgt = 32'h40;
        rdy = 1'b1; deq_ready = 1'b1;
        wait_req(3);
        check_eq("tk_req2", 64'(req_q[2]), 64'h40);
        wait_deq(2);
        check_eq("tk_deq1_pc",  64'(dq_pc[1]),  64'h4);
        check_eq("tk_deq1_tk",  64'(dq_tk[1]),  64'd1);
        check_eq("tk_deq1_npc", 64'(dq_npc[1]), 64'h40);
        check_eq("tk_deq0_tk",  64'(dq_tk[0]),  64'd0);
        check_eq("tk_deq0_npc", 64'(dq_npc[0]), 64'h4);

        // Fill to capacity with the decoder stalled
        do_reset();
        rdy = 1'b1; deq_ready = 1'b0;
        repeat (12) step();
        check_eq("full_nreq",      64'(req_q.size()),     64'd4);
        check_eq("full_req3",      64'(req_q[3]),         64'hC);
        check_eq("full_count",     64'(queue_count),      64'd4);
        check_eq("full_req_valid", 64'(icache_req_valid), 64'd0);
        check_eq("full_deq_valid", 64'(deq_valid),        64'd1);
        check_eq("full_head_pc",   64'(deq_pc),           64'h0);
        check_eq("full_head_inst", 64'(deq_inst),         64'hC0DE_0000);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check_eq("pop1_count",     64'(queue_count),      64'd3);
        check_eq("pop1_req_valid", 64'(icache_req_valid), 64'd1);
        check_eq("pop1_req_addr",  64'(icache_req_addr),  64'h10);
        repeat (4) step();
        check_eq("refill_nreq",  64'(req_q.size()), 64'd5);
        check_eq("refill_count", 64'(queue_count),  64'd4);

        // rdy low freezes issue and dequeue
        rdy = 1'b0; deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("frz_deq_valid", 64'(deq_valid),        64'd0);
            check_eq("frz_req_valid", 64'(icache_req_valid), 64'd0);
            check_eq("frz_count",     64'(queue_count),      64'd4);
            step();
        end
        check_eq("frz_ndeq", 64'(dq_pc.size()), 64'd1);
        rdy = 1'b1;
        repeat (12) step();
        check_eq("res_deq1", 64'(dq_pc[1]), 64'h4);
        check_eq("res_deq2", 64'(dq_pc[2]), 64'h8);
        check_eq("res_deq3", 64'(dq_pc[3]), 64'hC);
        check_eq("res_deq4", 64'(dq_pc[4]), 64'h10);
        check_eq("res_req5", 64'(req_q[5]), 64'h14);

        // Redirect while waiting on a slow response
        lat = 3;
        do_reset();
        rdy = 1'b1; deq_ready = 1'b0;
        wait_req(3);
        check_eq("rdw_pre_count", 64'(queue_count), 64'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check_eq("rdw_count",     64'(queue_count),      64'd0);
        check_eq("rdw_deq_valid", 64'(deq_valid),        64'd0);
        check_eq("rdw_req_valid", 64'(icache_req_valid), 64'd0);
        wait_req(4);
        check_eq("rdw_req3",        64'(req_q[3]),    64'h100);
        check_eq("rdw_drop_count",  64'(queue_count), 64'd0);
        deq_ready = 1'b1;
        wait_deq(1);
        check_eq("rdw_deq0_pc",   64'(dq_pc[0]),   64'h100);
        check_eq("rdw_deq0_inst", 64'(dq_inst[0]), 64'hC0DE_0100);

        // Redirect coinciding with a response; unaligned target
        lat = 1;
        do_reset();
        rdy = 1'b1; deq_ready = 1'b0;
        wait_req(3);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        check_eq("rds_req_valid", 64'(icache_req_valid), 64'd1);
        check_eq("rds_req_addr",  64'(icache_req_addr),  64'h100);
        check_eq("rds_count",     64'(queue_count),      64'd0);
        deq_ready = 1'b1;
        wait_deq(1);
        check_eq("rds_deq0_pc", 64'(dq_pc[0]), 64'h100);

        // Reset during an outstanding request; the late response is ignored
        lat = 3;
        do_reset();
        rdy = 1'b1;
        wait_req(1);
        rdy = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check_eq("stale_count",    64'(queue_count),     64'd0);
        check_eq("stale_req_addr", 64'(icache_req_addr), 64'h0);
        rdy = 1'b1;
        #1;
        check_eq("stale_req_valid", 64'(icache_req_valid), 64'd1);
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch unit with a decoupling queue between the instruction cache and the decoder. Generates sequential and predicted fetch addresses, keeps one request outstanding, buffers up to QUEUE_DEPTH fetched instructions with their PC and prediction, and flushes cleanly on redirect from the flow controller. Stale cache responses that arrive after a redirect are discarded by the block.

## Interface
- XLEN, 32, address/PC width
- INST_W, 32, instruction width
- QUEUE_DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low pauses the block
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  restart address
- icache_req_valid  out  1  fetch request
- icache_req_addr  out  XLEN  request address, word-aligned
- icache_req_ready  in  1  cache accepts request
- icache_resp_valid  in  1  instruction returned, one-cycle pulse
- icache_resp_inst  in  INST_W  returned instruction
- pred_pc  out  XLEN  PC of the instruction being returned (predictor lookup)
- pred_next_pc  in  XLEN  predicted next PC, combinational from pred_pc
- pred_taken  in  1  prediction is a taken jump
- deq_valid  out  1  queue head valid
- deq_ready  in  1  decoder consumes head
- deq_inst  out  INST_W  head instruction
- deq_pc  out  XLEN  head PC
- deq_pred_next_pc  out  XLEN  head predicted next PC
- deq_pred_taken  out  1  head prediction bit
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

## Operation
- Registers: fetch_pc, inflight_pc, FSM state, queue.
- FSM states: S_REQ, S_WAIT, S_DROP.
- S_REQ: icache_req_valid = rdy && (queue_count < QUEUE_DEPTH), addr = fetch_pc. On valid && ready: inflight_pc <= fetch_pc, go S_WAIT.
- S_WAIT: pred_pc = inflight_pc. On icache_resp_valid: enqueue {inst, inflight_pc, pred_next_pc, pred_taken}; fetch_pc <= pred_next_pc; go S_REQ.
- S_DROP: on icache_resp_valid discard response, go S_REQ; no enqueue.
- Slot reservation: a request issues only if a free slot exists counting the outstanding one, so an enqueue never meets a full queue.
- Redirect (highest priority): queue flushed (count 0), fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}. From S_WAIT, or S_REQ with handshake in the same cycle, go S_DROP; from S_DROP stay S_DROP; else S_REQ. A response in the redirect cycle is discarded and clears the S_DROP obligation (go S_REQ).
- Dequeue: deq_valid = rdy && count>0; head pops on deq_valid && deq_ready && !redirect_valid.
- rdy low: no request, no dequeue, fetch_pc and FSM frozen; a cache response is still captured/dropped per state.
- Pointers wrap modulo QUEUE_DEPTH; count updates +1, −1 or 0 for simultaneous enqueue and dequeue.

## Timing
- Reset: icache_req_valid 0, icache_req_addr RESET_PC, deq_valid 0, queue_count 0, deq_* 0, state S_REQ, fetch_pc RESET_PC.
- First request in the first cycle after rst_n deasserts (if rdy).
- Response in cycle t → deq_valid at t+1 (registered queue, no bypass); next request at t+1.
- Redirect in cycle t → deq_valid 0 at t+1; request to redirect_pc at t+1 unless S_DROP is pending a response.
- Throughput: one instruction per two cycles at single-cycle cache latency.
- rst_n asserted mid-request: all state reset immediately; any later response is ignored (state S_REQ, no inflight).

## Structure
- Shared package fetch_pkg: XLEN, INST_W defaults, state enum (S_REQ/S_WAIT/S_DROP), queue entry struct {inst, pc, pred_next_pc, pred_taken}.
- Sub-module fetch_fifo: circular buffer with synchronous flush, enq/deq, count output; parametrised on entry width and depth.

## Test plan
- Reset, rdy=1, cache 1-cycle, pred_next_pc=pc+4, deq_ready=1 -> requests 0x0,0x4,0x8; deq_pc sequence 0x0,0x4,0x8 with matching insts.
- deq_ready=0, QUEUE_DEPTH=4 -> exactly 4 requests, queue_count 4, icache_req_valid stays 0; deq_ready=1 for one cycle -> count 3, one new request.
- Redirect to 0x100 while S_WAIT for 0x8 -> count 0, response for 0x8 dropped, next request 0x100, first deq_pc 0x100.
- Redirect and icache_resp_valid same cycle -> response dropped, request 0x100 the following cycle.
- pred_taken=1, pred_next_pc=0x40 on PC 0x4 -> next request 0x40; deq entry for 0x4 carries pred_taken=1, pred_next_pc=0x40.
- rdy=0 for 3 cycles with entries queued -> deq_valid 0, no requests, count unchanged; resumes identically when rdy=1.
